visumon_scheduler: RTL

- Shares the single visuMon debug-info write port between NUM_REQ independent requesters (CPU glue, memory controller, reset sequencer, etc.).
- Each requester has a one-deep pending slot.
- A round-robin scheduler serialises the slot contents into properly timed active-low chip-select write cycles on visuMon's i_cs / i_debugInfo.
- Sits between the debug sources and the visuMon instance, in the i_clkVideo domain.

---
 rtl/visumon_scheduler_pkg.sv | 36 +++
 rtl/visumon_scheduler_rr_arbiter.sv | 41 ++++
 rtl/visumon_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/visumon_scheduler_pkg.sv
// Shared types for the visuMon write-port scheduler: debug payload,
// scheduler FSM states and an index-width helper for the round-robin pointer.
package visumon_scheduler_pkg;

    typedef enum logic [2:0] {
        colorBlack,
        colorRed,
        colorGreen,
        colorYellow,
        colorBlue,
        colorMagenta,
        colorCyan,
        colorWhite
    } color_t;

    typedef struct packed {
        logic [3:0] ledNo;
        color_t     color;
        logic       status;
    } debugInfo_t;

    typedef enum logic [1:0] {
        vmsIdle,
        vmsSetup,
        vmsStrobe,
        vmsGap
    } vmsState_t;

    localparam int unsigned VMS_WORD_W = 32;

    // Bits needed to hold an index 0..n-1, never less than one bit.
    function automatic int unsigned vmsIdxWidth(input logic [VMS_WORD_W-1:0] n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/visumon_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set bit of pend_i at or above
// rrPtr_i, wrapping around to index 0 when nothing above it is pending.
module visumon_scheduler_rr_arbiter
    import visumon_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = vmsIdxWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend_i,
    input  logic [PTR_W-1:0]   rrPtr_i,
    output logic [PTR_W-1:0]   grant_o,
    output logic               anyGrant_o
);

    logic             hiFound;
    logic             loFound;
    logic [PTR_W-1:0] hiIdx;
    logic [PTR_W-1:0] loIdx;

    // Scan downward so the lowest pending index in each half wins; the upper half (>= pointer) has priority.
    always_comb begin
        hiFound = 1'b0;
        loFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (pend_i[j]) begin
                if (PTR_W'(j) >= rrPtr_i) begin
                    hiFound = 1'b1;
                    hiIdx   = PTR_W'(j);
                end else begin
                    loFound = 1'b1;
                    loIdx   = PTR_W'(j);
                end
            end
        end
        anyGrant_o = hiFound | loFound;
        grant_o    = hiFound ? hiIdx : loIdx;
    end

endmodule

// File: rtl/visumon_scheduler.sv
// Shares the single visuMon debug-info write port among NUM_REQ requesters.
// Each requester owns a one-deep slot; a round-robin FSM turns slot contents
// into SETUP / STROBE (cs low) / GAP write cycles on the visuMon interface.
module visumon_scheduler
    import visumon_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_valid,
    input  debugInfo_t [NUM_REQ-1:0] i_debugInfo,
    output logic [NUM_REQ-1:0]       o_accept,
    output logic [NUM_REQ-1:0]       o_overrun,
    input  logic                     i_clrOverrun,
    output logic                     o_cs,
    output debugInfo_t               o_debugInfo,
    output logic                     o_busy,
    output logic [15:0]              o_writeCount
);

    localparam int unsigned PTR_W = vmsIdxWidth(NUM_REQ);
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    vmsState_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cs_q, cs_d;
    logic               grantFire;
    logic               writeDone;
    logic [PTR_W-1:0]   grantIdx;
    logic               anyGrant;
    logic [PTR_W-1:0]   rrPtr_q;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] overrun_q, overrun_d;
    logic [NUM_REQ-1:0] overrunSet;
    logic [NUM_REQ-1:0] accept_q;
    debugInfo_t         slot_q [NUM_REQ];
    debugInfo_t         data_q;
    logic [15:0]        writeCount_q;

    visumon_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arbiter (
        .pend_i     (pend_q),
        .rrPtr_i    (rrPtr_q),
        .grant_o    (grantIdx),
        .anyGrant_o (anyGrant)
    );

    // FSM state, phase counter and chip select register; reset aborts any write in flight.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= vmsIdle;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
        end
    end

    // Next state: grant from IDLE, one SETUP cycle, HOLD_CYCLES of cs low, then GAP_CYCLES of recovery.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cs_d      = cs_q;
        grantFire = 1'b0;
        writeDone = 1'b0;
        case (state_q)
            vmsIdle: begin
                cs_d = 1'b1;
                if (anyGrant) begin
                    grantFire = 1'b1;
                    state_d   = vmsSetup;
                end
            end
            vmsSetup: begin
                state_d = vmsStrobe;
                cs_d    = 1'b0;
                cnt_d   = HOLD_LOAD;
            end
            vmsStrobe: begin
                if (cnt_q == '0) begin
                    state_d   = vmsGap;
                    cs_d      = 1'b1;
                    writeDone = 1'b1;
                    cnt_d     = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            vmsGap: begin
                if (cnt_q == '0) begin
                    state_d = vmsIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = vmsIdle;
                cs_d    = 1'b1;
            end
        endcase
    end

    // Pending/overrun bookkeeping; a slot being granted this cycle may be refilled without counting as an overrun.
    always_comb begin
        pend_d     = pend_q;
        overrunSet = '0;
        if (grantFire) begin
            pend_d[grantIdx] = 1'b0;
        end
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (i_valid[k]) begin
                pend_d[k] = 1'b1;
                if (pend_q[k] && !(grantFire && (grantIdx == PTR_W'(k)))) begin
                    overrunSet[k] = 1'b1;
                end
            end
        end
        overrun_d = i_clrOverrun ? overrunSet : (overrun_q | overrunSet);
    end

    // Slot capture, grant-time payload latch, round-robin pointer and completed-write counter.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            pend_q       <= '0;
            overrun_q    <= '0;
            accept_q     <= '0;
            rrPtr_q      <= '0;
            data_q       <= '0;
            writeCount_q <= '0;
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            accept_q  <= i_valid;
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                if (i_valid[k]) begin
                    slot_q[k] <= i_debugInfo[k];
                end
            end
            if (grantFire) begin
                data_q  <= slot_q[grantIdx];
                rrPtr_q <= (grantIdx == LAST_IDX) ? '0 : grantIdx + PTR_W'(1);
            end
            if (writeDone) begin
                writeCount_q <= writeCount_q + 16'd1;
            end
        end
    end

    assign o_cs         = cs_q;
    assign o_debugInfo  = data_q;
    assign o_accept     = accept_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != vmsIdle);
    assign o_writeCount = writeCount_q;

endmodule
